// File: rtl/kb_event_queue_if.sv
// Byte-stream input and event-pop handshake for kb_event_queue.
interface kb_event_queue_if;
    logic        i_byte_en;
    logic [7:0]  i_byte;
    logic        i_ready;
    logic        o_valid;
    logic [13:0] o_evt;

    modport master (
        output i_byte_en, i_byte, i_ready,
        input  o_valid, o_evt
    );

    modport slave (
        input  i_byte_en, i_byte, i_ready,
        output o_valid, o_evt
    );
endinterface

// File: rtl/kb_event_queue.sv
// PS/2 set-2 decoder with modifier tracking feeding a FWFT event FIFO.
// Optional typematic repeat suppression: define KB_REPEAT_FILTER_EN.
module kb_event_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_sclr_n,
    kb_event_queue_if.slave  bus,
    input  logic             i_ovf_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    output logic             o_shift,
    output logic             o_ctrl,
    output logic             o_alt,
    output logic             o_capslock
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EVT_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE
    } state_t;

    state_t     r_state;
    logic [2:0] r_skip;

    logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
    logic       r_caps, r_caps_held;
    logic       r_shift, r_ctrl, r_alt;

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid, r_ovf;

    logic       w_emit, w_brk, w_ext, w_fake, w_make, w_supp, w_push;
    logic [7:0] w_code;
    logic       w_lshift_n, w_rshift_n, w_lctrl_n, w_rctrl_n, w_lalt_n, w_ralt_n;
    logic       w_caps_n, w_caps_held_n;
    logic       w_shift_n, w_ctrl_n, w_alt_n;
    logic [EVT_W-1:0] w_evt;
    logic       w_pop, w_full, w_wr, w_drop;
    logic [CNT_W-1:0] w_count_n;

    assign w_code = bus.i_byte;
    assign w_fake = (bus.i_byte == 8'h12) || (bus.i_byte == 8'h59);

    // Event emission for the byte presented this cycle
    always_comb begin
        w_emit = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        if (bus.i_byte_en) begin
            case (r_state)
                ST_IDLE: begin
                    case (bus.i_byte)
                        8'hE0, 8'hF0, 8'hE1,
                        8'h00, 8'hAA, 8'hEE, 8'hFA,
                        8'hFC, 8'hFD, 8'hFE, 8'hFF: w_emit = 1'b0;
                        default:                     w_emit = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    w_ext  = 1'b1;
                    w_emit = !(bus.i_byte == 8'hF0 || bus.i_byte == 8'hE0 ||
                               bus.i_byte == 8'hE1 || w_fake);
                end
                ST_BRK: begin
                    w_emit = 1'b1;
                    w_brk  = 1'b1;
                end
                ST_EXT_BRK: begin
                    w_ext  = 1'b1;
                    w_brk  = 1'b1;
                    w_emit = !w_fake;
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    // Prefix tracking; pause bytes are swallowed by counting down r_skip
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            r_state <= ST_IDLE;
            r_skip  <= 3'd0;
        end else if (bus.i_byte_en) begin
            case (r_state)
                ST_IDLE: begin
                    case (bus.i_byte)
                        8'hE0: r_state <= ST_EXT;
                        8'hF0: r_state <= ST_BRK;
                        8'hE1: begin
                            r_state <= ST_PAUSE;
                            r_skip  <= 3'd7;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
                ST_EXT: begin
                    if (bus.i_byte == 8'hF0)
                        r_state <= ST_EXT_BRK;
                    else if (bus.i_byte == 8'hE0 || bus.i_byte == 8'hE1)
                        r_state <= ST_EXT;
                    else
                        r_state <= ST_IDLE;
                end
                ST_PAUSE: begin
                    r_skip <= r_skip - 3'd1;
                    if (r_skip == 3'd1)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_make = w_emit & ~w_brk;

`ifdef KB_REPEAT_FILTER_EN
    logic       r_lm_valid, r_lm_ext;
    logic [7:0] r_lm_code;
    logic       w_lm_match;

    assign w_lm_match = r_lm_valid && (r_lm_ext == w_ext) && (r_lm_code == w_code);
    assign w_supp     = w_make & w_lm_match;

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            r_lm_valid <= 1'b0;
            r_lm_ext   <= 1'b0;
            r_lm_code  <= 8'h00;
        end else if (w_make) begin
            r_lm_valid <= 1'b1;
            r_lm_ext   <= w_ext;
            r_lm_code  <= w_code;
        end else if (w_emit && w_brk && w_lm_match) begin
            r_lm_valid <= 1'b0;
        end
    end
`else
    assign w_supp = 1'b0;
`endif

    assign w_push = w_emit & ~w_supp;

    // Post-update modifier state so the snapshot reflects this event
    always_comb begin
        w_lshift_n    = r_lshift;
        w_rshift_n    = r_rshift;
        w_lctrl_n     = r_lctrl;
        w_rctrl_n     = r_rctrl;
        w_lalt_n      = r_lalt;
        w_ralt_n      = r_ralt;
        w_caps_n      = r_caps;
        w_caps_held_n = r_caps_held;
        if (w_push) begin
            case ({w_ext, w_code})
                {1'b0, 8'h12}: w_lshift_n = ~w_brk;
                {1'b0, 8'h59}: w_rshift_n = ~w_brk;
                {1'b0, 8'h14}: w_lctrl_n  = ~w_brk;
                {1'b1, 8'h14}: w_rctrl_n  = ~w_brk;
                {1'b0, 8'h11}: w_lalt_n   = ~w_brk;
                {1'b1, 8'h11}: w_ralt_n   = ~w_brk;
                {1'b0, 8'h58}: begin
                    if (w_brk) begin
                        w_caps_held_n = 1'b0;
                    end else begin
                        if (!r_caps_held)
                            w_caps_n = ~r_caps;
                        w_caps_held_n = 1'b1;
                    end
                end
                default: w_caps_n = r_caps;
            endcase
        end
    end

    assign w_shift_n = w_lshift_n | w_rshift_n;
    assign w_ctrl_n  = w_lctrl_n  | w_rctrl_n;
    assign w_alt_n   = w_lalt_n   | w_ralt_n;
    assign w_evt     = {w_caps_n, w_alt_n, w_ctrl_n, w_shift_n, w_ext, w_brk, w_code};

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_lalt      <= 1'b0;
            r_ralt      <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_shift     <= 1'b0;
            r_ctrl      <= 1'b0;
            r_alt       <= 1'b0;
        end else begin
            r_lshift    <= w_lshift_n;
            r_rshift    <= w_rshift_n;
            r_lctrl     <= w_lctrl_n;
            r_rctrl     <= w_rctrl_n;
            r_lalt      <= w_lalt_n;
            r_ralt      <= w_ralt_n;
            r_caps      <= w_caps_n;
            r_caps_held <= w_caps_held_n;
            r_shift     <= w_shift_n;
            r_ctrl      <= w_ctrl_n;
            r_alt       <= w_alt_n;
        end
    end

    // FIFO: a pop frees the slot a full-queue push needs in the same cycle
    assign w_pop  = r_valid & bus.i_ready;
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_comb begin
        case ({w_wr, w_pop})
            2'b10:   w_count_n = r_count + CNT_W'(1);
            2'b01:   w_count_n = r_count - CNT_W'(1);
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_evt;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_n;
            r_valid <= (w_count_n != '0);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_evt   = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_overflow  = r_ovf;
    assign o_shift     = r_shift;
    assign o_ctrl      = r_ctrl;
    assign o_alt       = r_alt;
    assign o_capslock  = r_caps;
endmodule

// File: tb/tb_kb_event_queue.sv
// Scoreboard bench for kb_event_queue: expected events queued at stimulus, checked on pop.
module tb_kb_event_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             i_sclr_n;
    logic             i_ovf_clr;
    logic [CNT_W-1:0] o_count;
    logic             o_overflow, o_shift, o_ctrl, o_alt, o_capslock;

    kb_event_queue_if bus ();

    kb_event_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .i_sclr_n   (i_sclr_n),
        .bus        (bus),
        .i_ovf_clr  (i_ovf_clr),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_shift    (o_shift),
        .o_ctrl     (o_ctrl),
        .o_alt      (o_alt),
        .o_capslock (o_capslock)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [13:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted pop must match the oldest expected event
    always @(negedge clk) begin
        if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_evt", 32'(bus.o_evt), 32'hFFFF_FFFF);
            else
                chk("evt", 32'(bus.o_evt), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [7:0] b);
        bus.i_byte    = b;
        bus.i_byte_en = 1'b1;
        @(posedge clk);
        #1;
        bus.i_byte_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.i_ready = 1'b1;
        while ((bus.o_valid || exp_q.size() != 0) && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.i_ready = 1'b0;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_cnt", 32'(o_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_sclr_n      = 1'b0;
        i_ovf_clr     = 1'b0;
        bus.i_byte_en = 1'b0;
        bus.i_byte    = 8'h00;
        bus.i_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_evt", 32'(bus.o_evt), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_mods", 32'({o_shift, o_ctrl, o_alt, o_capslock}), 32'd0);
        i_sclr_n = 1'b1;

        // make/break of 'A'
        exp_q.push_back(14'h01C);
        send(8'h1C);
        chk("valid_first", 32'(bus.o_valid), 32'd1);
        exp_q.push_back(14'h11C);
        send(8'hF0);
        send(8'h1C);
        chk("cnt_ab", 32'(o_count), 32'd2);
        drain();

        // shifted letter
        exp_q.push_back(14'h412);
        send(8'h12);
        chk("shift_on", 32'(o_shift), 32'd1);
        exp_q.push_back(14'h41C);
        send(8'h1C);
        exp_q.push_back(14'h112);
        send(8'hF0);
        send(8'h12);
        chk("shift_off", 32'(o_shift), 32'd0);
        drain();

        // extended make/break, fake shift discarded
        exp_q.push_back(14'h275);
        send(8'hE0); send(8'h75);
        exp_q.push_back(14'h375);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        chk("cnt_ext", 32'(o_count), 32'd2);
        chk("ext_shift", 32'(o_shift), 32'd0);
        drain();

        // capslock with typematic repeat
        exp_q.push_back(14'h2058);
        send(8'h58);
        chk("caps1", 32'(o_capslock), 32'd1);
`ifndef KB_REPEAT_FILTER_EN
        exp_q.push_back(14'h2058);
`endif
        send(8'h58);
        chk("caps2", 32'(o_capslock), 32'd1);
        exp_q.push_back(14'h2158);
        send(8'hF0); send(8'h58);
        chk("caps3", 32'(o_capslock), 32'd1);
        exp_q.push_back(14'h0058);
        send(8'h58);
        chk("caps4", 32'(o_capslock), 32'd0);
`ifdef KB_REPEAT_FILTER_EN
        chk("cnt_caps", 32'(o_count), 32'd3);
`else
        chk("cnt_caps", 32'(o_count), 32'd4);
`endif
        drain();

        // fill, overflow, full push+pop, overflow clear
        for (int i = 0; i < 9; i++) begin
            if (i < 8)
                exp_q.push_back(14'(8'h1C + 8'(i)));
            send(8'h1C + 8'(i));
            if (i == 7) begin
                chk("cnt_full", 32'(o_count), 32'd8);
                chk("ovf_pre", 32'(o_overflow), 32'd0);
            end
        end
        chk("cnt_ovf", 32'(o_count), 32'd8);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        exp_q.push_back(14'h02B);
        bus.i_ready = 1'b1;
        send(8'h2B);
        bus.i_ready = 1'b0;
        chk("cnt_full_pp", 32'(o_count), 32'd8);
        chk("ovf_hold", 32'(o_overflow), 32'd1);
        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(o_overflow), 32'd0);
        drain();

        // pause sequence produces nothing
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("cnt_pause", 32'(o_count), 32'd0);
        exp_q.push_back(14'h01C);
        send(8'h1C);
        chk("cnt_after_pause", 32'(o_count), 32'd1);
        chk("ctrl_pause", 32'(o_ctrl), 32'd0);
        drain();

        // reset discards a pending E0 prefix
        send(8'hE0);
        i_sclr_n = 1'b0;
        @(posedge clk);
        #1;
        i_sclr_n = 1'b1;
        exp_q.push_back(14'h075);
        send(8'h75);
        chk("cnt_post_rst", 32'(o_count), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/kb_event_queue.md
Name: kb_event_queue

Overview:
- Parametrised successor to the keyboard front end's scan-code/shift handling.
- Consumes the received-byte stream (byte + strobe) from the PS/2 receiver and decodes set-2 prefixes (E0 extended, F0 break, E1 pause).
- Tracks modifier state (shift, ctrl, alt, capslock) and pushes complete key events, tagged with a modifier snapshot, into a FIFO of configurable depth.
- Downstream logic pops events with a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of o_count (derived; do not override)

Ports:
clk  in  1  system clock
i_sclr_n  in  1  synchronous active-low reset
i_byte_en  in  1  one-cycle strobe: i_byte holds a new received byte
i_byte  in  8  received byte
i_ready  in  1  consumer pops head event when high with o_valid
i_ovf_clr  in  1  clears o_overflow
o_valid  out  1  FIFO non-empty
o_evt  out  14  head event: [7:0] code, [8] break, [9] extended, [10] shift, [11] ctrl, [12] alt, [13] capslock
o_count  out  CNT_W  events stored
o_overflow  out  1  sticky: event dropped because FIFO full
o_shift, o_ctrl, o_alt, o_capslock  out  1 each  live modifier state

Behaviour:
- Reset (i_sclr_n=0 at clk edge): decoder FSM=IDLE, FIFO empty, all outputs 0, o_evt=0, modifiers/held flags cleared. Reset mid-sequence discards partial prefixes.
- Bytes are processed only on cycles with i_byte_en=1; other cycles leave FSM unchanged.
- Decoder FSM:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE (skip=7); 00/AA/EE/FA/FC/FD/FE/FF dropped, stays IDLE; any other byte emits make{ext=0}.
  - EXT: F0->EXT_BRK; E0/E1 ignored (stays); 12 or 59 (fake shift) discarded ->IDLE; other byte emits make{ext=1} ->IDLE.
  - BRK: any byte emits break{ext=0} ->IDLE.
  - EXT_BRK: 12/59 discarded ->IDLE; other byte emits break{ext=1} ->IDLE.
  - PAUSE: discards each byte and decrements skip; at skip=1 the byte is discarded and state ->IDLE. No event is emitted for pause.
- Modifiers update in the same cycle as the event they cause. Snapshot fields [13:10] carry post-update values.
  - Shift = lshift(12,ext0) | rshift(59,ext0).
  - Ctrl = lctrl(14,ext0) | rctrl(14,ext1).
  - Alt = lalt(11,ext0) | ralt(11,ext1).
  - Make sets the corresponding held bit; break clears it.
  - Capslock (58,ext0) toggles on make only when caps_held=0, then sets caps_held; break clears caps_held. Typematic repeats therefore toggle once.
- FIFO (first-word fall-through):
  - Event emitted in cycle N is written at the end of N; o_valid=1 from N+1 if the FIFO was empty.
  - Pop occurs when o_valid&i_ready; o_evt shows the next entry the following cycle.
  - Push when full with no pop: event dropped, o_overflow=1 from next cycle, count unchanged.
  - Push when full with a simultaneous pop: accepted, count stays DEPTH.
  - Push+pop when empty: push accepted, pop ignored (o_valid was 0).
  - Pointers wrap modulo DEPTH.
  - o_overflow clears on i_ovf_clr unless a drop occurs in the same cycle (the drop wins).
- o_count is always the exact number of stored entries, 0..DEPTH.

Optional Feature:
- Macro KB_REPEAT_FILTER_EN.
- Defined: a last_make register {valid, ext, code} is kept. A make identical to last_make while valid=1 is suppressed (no push, modifiers unchanged). Any make updates last_make. A break matching last_make clears valid. Reset clears valid.
- Undefined: every typematic make is pushed as its own event.

Test Plan:
- Bytes 1C, F0 1C -> two events: 0x01C (make 'A') then 0x11C (break); o_count=2; pops return them in order.
- Bytes 12, 1C, F0 12 -> events 0x412, 0x41C, 0x112; o_shift=0 at end.
- Bytes E0 75, E0 F0 75, E0 12 -> events 0x275, 0x375; fake-shift discarded; o_count=2.
- Bytes 58, 58, F0 58, 58 -> o_capslock 1,1,1,0. Without KB_REPEAT_FILTER_EN: 4 events. With it: the second 58 is suppressed, 3 events.
- DEPTH=8: push 9 makes without popping -> o_count=8, o_overflow=1. Full + simultaneous pop and push -> count stays 8. i_ovf_clr -> o_overflow=0.
- E1 14 77 E1 F0 14 F0 77 then 1C -> single event 0x01C. i_sclr_n low after an E0 byte -> the next 75 yields 0x075 with ext=0.
